// File: rtl/computie_bus_pkg.sv
// Types and helpers shared by the computie bus controller and its bus targets.
package computie_bus_pkg;

  // Bus target handshake states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACK    = 2'd2,
    ST_IGNORE = 2'd3
  } bus_target_state_t;

  // Default register bank base address on the 8-bit bus.
  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h40;

  // Width of the acknowledge delay counter (delays 0..15).
  localparam int ACK_CNT_W = 4;

  // Number of registers decoded by a given count of low address bits.
  function automatic int num_regs(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/computie_sync2.sv
// Two-flop synchronizer for an asynchronous bus pin, with a falling-edge
// detector on the synchronized output. Flops come out of reset at RESET_VAL
// so an idle-high pin does not produce a spurious edge after reset.
module computie_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s2_prev_q;

  // Synchronizer chain plus one-cycle history of the synchronized level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= RESET_VAL;
      s2_q      <= RESET_VAL;
      s2_prev_q <= RESET_VAL;
    end else begin
      s1_q      <= async_i;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = !s2_q && s2_prev_q;

endmodule

// File: rtl/computie_bus_regs.sv
// Register-bank bus target behind computie_bus_ctrl. Decodes the latched
// address on the synchronized strobe falling edge, waits ACK_DELAY cycles,
// performs the read or write and holds data_ack low until the strobe releases.
module computie_bus_regs
  import computie_bus_pkg::*;
#(
  parameter int                  BITWIDTH    = 8,
  parameter int                  ADDR_BITS   = 2,
  parameter logic [BITWIDTH-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int                  ACK_DELAY   = 2,
  parameter logic [BITWIDTH-1:0] RESET_VALUE = '0,
  localparam int                 NUM_REGS    = num_regs(ADDR_BITS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         addr_strobe,
  input  logic                         read_write,
  input  logic [BITWIDTH-1:0]          addr_in,
  input  logic [BITWIDTH-1:0]          data_in,
  output logic [BITWIDTH-1:0]          data_out,
  output logic                         data_ack,
  output logic                         selected,
  output logic [NUM_REGS*BITWIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  logic strobe_sync;
  logic strobe_fall;

  computie_sync2 #(
    .RESET_VAL (1'b1)
  ) u_strobe_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (addr_strobe),
    .sync_o  (strobe_sync),
    .fall_o  (strobe_fall)
  );

  bus_target_state_t     state_q, state_d;
  logic [ACK_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [BITWIDTH-1:0]   data_out_q;
  logic [NUM_REGS-1:0]   pulse_q;
  logic [BITWIDTH-1:0]   regs_q [NUM_REGS];

  logic                  do_access;
  logic [ADDR_BITS-1:0]  acc_addr;
  logic                  acc_rd;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  addr_hit;

  assign addr_hit = (addr_in[BITWIDTH-1:ADDR_BITS] == BASE_ADDR[BITWIDTH-1:ADDR_BITS]);

  // State register and captured cycle attributes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic. The decode cycle counts as one of the wait cycles, so
  // the counter is loaded with ACK_DELAY-1 and a zero delay goes straight to
  // ACK; this keeps pin-fall to ack at ACK_DELAY+3 edges.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    do_access = 1'b0;
    acc_addr  = addr_q;
    acc_rd    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe_fall) begin
          addr_d = addr_in[ADDR_BITS-1:0];
          rd_d   = read_write;
          if (addr_hit) begin
            if (ACK_DELAY == 0) begin
              do_access = 1'b1;
              acc_addr  = addr_in[ADDR_BITS-1:0];
              acc_rd    = read_write;
              state_d   = ST_ACK;
            end else begin
              cnt_d   = ACK_CNT_W'(ACK_DELAY - 1);
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end
      ST_WAIT: begin
        if (strobe_sync) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = ST_ACK;
        end else begin
          cnt_d = cnt_q - ACK_CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (strobe_sync) state_d = ST_IDLE;
      end
      ST_IGNORE: begin
        if (strobe_sync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus handshake outputs decoded from the current state.
  always_comb begin
    data_ack = 1'b1;
    selected = 1'b0;
    case (state_q)
      ST_WAIT: selected = 1'b1;
      ST_ACK: begin
        selected = 1'b1;
        data_ack = 1'b0;
      end
      default: ;
    endcase
  end

  // Per-register storage, write strobes and flattened view.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_sel[gi] = do_access && !acc_rd && (acc_addr == ADDR_BITS'(gi));

      // Register gi is only ever changed by a completed bus write.
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= RESET_VALUE;
        end else if (wr_sel[gi]) begin
          regs_q[gi] <= data_in;
        end
      end

      assign regs_flat[gi*BITWIDTH +: BITWIDTH] = regs_q[gi];
    end
  endgenerate

  // Read data capture and write notification pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      pulse_q    <= '0;
    end else begin
      pulse_q <= wr_sel;
      if (do_access && acc_rd) begin
        data_out_q <= regs_q[acc_addr];
      end
    end
  end

  assign data_out     = data_out_q;
  assign reg_wr_pulse = pulse_q;

endmodule
